// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter_pkg
//  Description : Shared types and constants for the four-master round-robin
//                bus arbiter and its rotating priority encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_arbiter_pkg;

    // Owner index and request vector shapes
    typedef logic [1:0] owner_t;
    typedef logic [3:0] req_t;

    localparam owner_t C_OWNER_M0 = 2'd0;
    localparam owner_t C_OWNER_M1 = 2'd1;
    localparam owner_t C_OWNER_M2 = 2'd2;
    localparam owner_t C_OWNER_M3 = 2'd3;

    // Arbiter state encoding
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_t;

    // Convert a one-hot grant vector to the owner index
    function automatic owner_t onehot_to_idx(input req_t oh);
        return {oh[3] | oh[2], oh[3] | oh[1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : bus_rr_pick
//  Description : Combinational rotating priority encoder. Searches the
//                request vector starting one position after the pointer and
//                wrapping round to the pointer itself.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_rr_pick
    import bus_arbiter_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt,
    output logic       valid
);

    logic [1:0] w_idx;

    // First asserted request in the order ptr+1, ptr+2, ptr+3, ptr wins
    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        w_idx = ptr;
        for (int i = 1; i <= 4; i++) begin
            w_idx = ptr + i[1:0];
            if (!valid && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter
//  Description : Four-master round-robin bus arbiter with registered one-hot
//                grants and a programmable hold limit that forces a handoff
//                only when another master is waiting.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       m0_req,
    input  logic       m1_req,
    input  logic       m2_req,
    input  logic       m3_req,
    output logic       m0_get,
    output logic       m1_get,
    output logic       m2_get,
    output logic       m3_get,
    output logic       bus_busy,
    output logic [1:0] owner
);

    localparam bit              C_LIMITED   = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] C_HOLD_LAST =
        (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

    arb_state_t        r_state;
    req_t              r_get;
    logic              r_busy;
    owner_t            r_owner;
    owner_t            r_last;
    logic [HOLD_W-1:0] r_cnt;

    req_t   w_req;
    req_t   w_pick_req;
    owner_t w_pick_ptr;
    req_t   w_gnt;
    logic   w_valid;
    logic   w_owner_req;

    assign w_req       = {m3_req, m2_req, m1_req, m0_req};
    // The owner is masked so a valid pick means "someone else is waiting";
    // when the owner has dropped its request the mask changes nothing.
    assign w_pick_req  = w_req & ~r_get;
    assign w_pick_ptr  = (r_state == ST_OWNED) ? r_owner : r_last;
    assign w_owner_req = |(w_req & r_get);

    bus_rr_pick u_pick (
        .req   (w_pick_req),
        .ptr   (w_pick_ptr),
        .gnt   (w_gnt),
        .valid (w_valid)
    );

    // Arbitration FSM with hold counter and registered grant outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_get   <= '0;
            r_busy  <= 1'b0;
            r_owner <= C_OWNER_M0;
            r_last  <= C_OWNER_M3;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_state <= ST_OWNED;
                        r_get   <= w_gnt;
                        r_busy  <= 1'b1;
                        r_owner <= onehot_to_idx(w_gnt);
                        r_cnt   <= '0;
                    end
                end
                ST_OWNED: begin
                    if (w_owner_req) begin
                        // Counter only runs while someone else is waiting
                        if (w_valid && C_LIMITED) begin
                            if (r_cnt == C_HOLD_LAST) begin
                                r_get   <= w_gnt;
                                r_owner <= onehot_to_idx(w_gnt);
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end else if (w_valid) begin
                        r_get   <= w_gnt;
                        r_owner <= onehot_to_idx(w_gnt);
                        r_cnt   <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                        r_get   <= '0;
                        r_busy  <= 1'b0;
                        r_last  <= r_owner;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_get   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign m0_get   = r_get[0];
    assign m1_get   = r_get[1];
    assign m2_get   = r_get[2];
    assign m3_get   = r_get[3];
    assign bus_busy = r_busy;
    assign owner    = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arbiter
//  Description : Directed self-checking bench for bus_arbiter, covering a
//                MAX_HOLD=16 instance and an unlimited-hold instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

    logic       clk;
    logic       reset;
    logic       m0_req, m1_req, m2_req, m3_req;
    logic       m0_get, m1_get, m2_get, m3_get, bus_busy;
    logic [1:0] owner;

    logic       u0_req, u1_req, u2_req, u3_req;
    logic       u0_get, u1_get, u2_get, u3_get, u_busy;
    logic [1:0] u_owner;

    int total = 0;
    int bad   = 0;

    bus_arbiter #(.MAX_HOLD(16), .HOLD_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .m0_req   (m0_req),
        .m1_req   (m1_req),
        .m2_req   (m2_req),
        .m3_req   (m3_req),
        .m0_get   (m0_get),
        .m1_get   (m1_get),
        .m2_get   (m2_get),
        .m3_get   (m3_get),
        .bus_busy (bus_busy),
        .owner    (owner)
    );

    bus_arbiter #(.MAX_HOLD(0), .HOLD_W(5)) dut_unl (
        .clk      (clk),
        .reset    (reset),
        .m0_req   (u0_req),
        .m1_req   (u1_req),
        .m2_req   (u2_req),
        .m3_req   (u3_req),
        .m0_get   (u0_get),
        .m1_get   (u1_get),
        .m2_get   (u2_get),
        .m3_get   (u3_get),
        .bus_busy (u_busy),
        .owner    (u_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed state of each instance packed as {get[3:0], busy, owner}
    function automatic logic [6:0] obs_a();
        return {m3_get, m2_get, m1_get, m0_get, bus_busy, owner};
    endfunction

    function automatic logic [6:0] obs_u();
        return {u3_get, u2_get, u1_get, u0_get, u_busy, u_owner};
    endfunction

    // Expected packed state from a grant vector and owner index
    function automatic logic [6:0] ex(input logic [3:0] g, input logic [1:0] o);
        return {g, |g, o};
    endfunction

    task automatic chk(input string tag, input logic [6:0] o, input logic [6:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] eo;
        reset  = 1'b1;
        m0_req = 1'b0; m1_req = 1'b0; m2_req = 1'b0; m3_req = 1'b0;
        u0_req = 1'b0; u1_req = 1'b0; u2_req = 1'b0; u3_req = 1'b0;

        // Reset held with requests pending
        #2 reset = 1'b0;
        m0_req = 1'b1; m2_req = 1'b1;
        repeat (3) tick();
        chk("reset_hold", obs_a(), ex(4'b0000, 2'd0));
        chk("reset_hold_unl", obs_u(), ex(4'b0000, 2'd0));
        reset = 1'b1;
        #1 chk("after_release", obs_a(), ex(4'b0000, 2'd0));
        tick();
        chk("first_grant", obs_a(), ex(4'b0001, 2'd0));

        // All four requesting: 16-cycle rotation 0,1,2,3,0
        m1_req = 1'b1; m3_req = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            tick();
            eo = 2'((k / 16) % 4);
            chk($sformatf("rotate_k%0d", k), obs_a(), ex(4'b0001 << eo, eo));
        end

        // M0 drops with M1/M3 pending: M1 next, then M1 drops -> M3, no gap
        m0_req = 1'b0; m2_req = 1'b0;
        tick();
        chk("release_to_m1", obs_a(), ex(4'b0010, 2'd1));
        m1_req = 1'b0;
        tick();
        chk("release_to_m3", obs_a(), ex(4'b1000, 2'd3));

        // M2 sole requester for 100 cycles, no forced handoff
        m3_req = 1'b0; m2_req = 1'b1;
        tick();
        chk("m2_grant", obs_a(), ex(4'b0100, 2'd2));
        for (int k = 0; k < 100; k++) begin
            tick();
            chk($sformatf("m2_sole_k%0d", k), obs_a(), ex(4'b0100, 2'd2));
        end
        m2_req = 1'b0;
        tick();
        chk("m2_drop_idle", obs_a(), ex(4'b0000, 2'd2));
        m0_req = 1'b1; m3_req = 1'b1;
        tick();
        chk("after_m2_m3_wins", obs_a(), ex(4'b1000, 2'd3));

        // Asynchronous reset in the middle of an M1 grant
        m0_req = 1'b0; m3_req = 1'b0; m1_req = 1'b1;
        tick();
        chk("m1_before_reset", obs_a(), ex(4'b0010, 2'd1));
        #3 reset = 1'b0;
        #1 chk("async_reset_drop", obs_a(), ex(4'b0000, 2'd0));
        tick();
        chk("reset_edge_hold", obs_a(), ex(4'b0000, 2'd0));
        reset = 1'b1;
        #1 chk("release_no_grant", obs_a(), ex(4'b0000, 2'd0));
        tick();
        chk("m1_regrant", obs_a(), ex(4'b0010, 2'd1));

        // Unlimited hold: M0 keeps the bus while M1 waits
        u0_req = 1'b1; u1_req = 1'b1;
        tick();
        chk("unl_m0_grant", obs_u(), ex(4'b0001, 2'd0));
        for (int k = 0; k < 40; k++) begin
            tick();
            chk($sformatf("unl_hold_k%0d", k), obs_u(), ex(4'b0001, 2'd0));
        end
        u0_req = 1'b0;
        tick();
        chk("unl_to_m1", obs_u(), ex(4'b0010, 2'd1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
